// File: rtl/demux8_buf_pkg.sv
// Shared definitions for the buffered 1-to-8 demultiplexer and its mux8 counterpart.
// Channel count, select width, slot state encoding and one-hot / population-count helpers.
package demux8_buf_pkg;

    localparam int DEMUX_CH = 8;
    localparam int SEL_W    = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // 3-bit select to 8-bit one-hot; shared with mux8 users.
    function automatic logic [DEMUX_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [DEMUX_CH-1:0] r;
        r = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

    // Number of set bits in an 8-bit vector; the 0..8 result fits in 4 bits.
    function automatic logic [3:0] popcount8(input logic [DEMUX_CH-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEMUX_CH; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux8_buf_slot.sv
// One output channel of demux8_buf: a single-entry valid/data register.
// A write wins over a same-cycle drain, so a full slot can be refilled while it is consumed.
module demux8_slot
    import demux8_buf_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [Width-1:0] data
);

    slot_state_e state;

    assign valid = (state == SLOT_FULL);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SLOT_EMPTY;
            // NOTE: the data register is cleared too, so a consumer never sees stale bits after reset.
            data  <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
            state <= SLOT_FULL;
            data  <= wr_data;
        end else if (valid && rd_ready) begin
            // Drained: data keeps its last value, only the valid flag drops.
            state <= SLOT_EMPTY;
        end
    end

endmodule

// File: rtl/demux8_buf.sv
// Buffered 1-to-8 demultiplexer: routes one valid/ready word per cycle into one of eight
// single-entry output registers, with no combinational path from input data to outputs.
module demux8_buf
    import demux8_buf_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [Width-1:0]          in_data,
    output logic [DEMUX_CH-1:0]       out_valid,
    input  logic [DEMUX_CH-1:0]       out_ready,
    output logic [DEMUX_CH*Width-1:0] out_data,
    output logic [3:0]                occupancy
);

    logic [DEMUX_CH-1:0] sel_onehot;
    logic [DEMUX_CH-1:0] wr_en;
    logic [DEMUX_CH-1:0] fire_out;
    logic                fire_in;
    logic                occ_inc;
    logic [3:0]          occ_dec;
    logic [3:0]          occ_next;

    // Ready depends only on the selected channel, never on in_valid.
    assign in_ready   = ~out_valid[in_sel] | out_ready[in_sel];
    assign fire_in    = in_valid & in_ready;
    assign sel_onehot = onehot8(in_sel);
    assign fire_out   = out_valid & out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_en    = '0;
        occ_inc  = 1'b0;
        occ_dec  = '0;
        occ_next = occupancy;
        if (fire_in) begin
            wr_en   = sel_onehot;
            // A refill of a draining slot leaves the count unchanged.
            occ_inc = ~fire_out[in_sel];
        end
        occ_dec  = popcount8(fire_out & ~wr_en);
        occ_next = occupancy + 4'(occ_inc) - occ_dec;
    end

    for (genvar j = 0; j < DEMUX_CH; j++) begin : g_slot
        demux8_slot #(
            .Width (Width)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (wr_en[j]),
            .wr_data  (in_data),
            .rd_ready (out_ready[j]),
            .valid    (out_valid[j]),
            .data     (out_data[j*Width +: Width])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule

// File: tb/tb_demux8_buf.sv
// Directed testbench for demux8_buf with a per-channel scoreboard for randomized traffic.
// Inputs change 1 ns after posedge; outputs are compared away from the clock edge.
module tb_demux8_buf;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [8*W-1:0] out_data;
    logic [3:0]     occupancy;

    int vectors    = 0;
    int miscompares = 0;

    demux8_buf #(.Width(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(reset_n === 1'b1 && in_valid === 1'b1 && $isunknown(in_sel)))
            else $error("FAIL sel_x: in_sel=%b while in_valid=1", in_sel);
    end

    function automatic logic [W-1:0] slot(input int j);
        return out_data[j*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 32'h5555_AAAA;
        out_ready = 8'h00;
        step();
        step();
        vectors++;
        if (out_valid !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_valid: got %h want 00", out_valid);
        end
        vectors++;
        if (occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_occ: got %0d want 0", occupancy);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
    endtask

    task automatic test_single_route();
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 8'h00;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL route_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'h20) begin
            miscompares++;
            $display("FAIL route_valid: got %h want 20", out_valid);
        end
        vectors++;
        if (slot(5) !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL route_data: got %h want deadbeef", slot(5));
        end
        vectors++;
        if (occupancy !== 4'd1) begin
            miscompares++;
            $display("FAIL route_occ: got %0d want 1", occupancy);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_sel   = 3'd5;
        in_data  = 32'hCAFE_0005;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_full: got %b want 0", in_ready);
        end
        step();
        vectors++;
        if (slot(5) !== 32'hDEAD_BEEF || out_valid !== 8'h20) begin
            miscompares++;
            $display("FAIL bp_hold: got data %h valid %h want deadbeef 20", slot(5), out_valid);
        end
        in_sel  = 3'd2;
        in_data = 32'h2222_2222;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_other: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 8'h24 || occupancy !== 4'd2) begin
            miscompares++;
            $display("FAIL bp_route_other: got valid %h occ %0d want 24 2", out_valid, occupancy);
        end
    endtask

    task automatic test_drain_refill();
        out_ready = 8'h20;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 32'h0000_1234;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL refill_ready: got %b want 1", in_ready);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        vectors++;
        if (out_valid !== 8'h24 || slot(5) !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL refill_data: got valid %h data %h want 24 00001234", out_valid, slot(5));
        end
        vectors++;
        if (occupancy !== 4'd2) begin
            miscompares++;
            $display("FAIL refill_occ: got %0d want 2", occupancy);
        end
    endtask

    task automatic test_fill_all();
        out_ready = 8'hFF;
        step();
        out_ready = 8'h00;
        vectors++;
        if (occupancy !== 4'd0 || out_valid !== 8'h00) begin
            miscompares++;
            $display("FAIL pre_fill_drain: got occ %0d valid %h want 0 00", occupancy, out_valid);
        end
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_sel   = 3'(s);
            in_data  = 32'hA000_0000 | 32'(s * 17);
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 8'hFF || occupancy !== 4'd8) begin
            miscompares++;
            $display("FAIL fill_all: got valid %h occ %0d want ff 8", out_valid, occupancy);
        end
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_ready sel=%0d: got %b want 0", s, in_ready);
            end
            vectors++;
            if (slot(s) !== (32'hA000_0000 | 32'(s * 17))) begin
                miscompares++;
                $display("FAIL fill_data ch=%0d: got %h want %h", s, slot(s),
                         32'hA000_0000 | 32'(s * 17));
            end
        end
        out_ready = 8'hFF;
        step();
        out_ready = 8'h00;
        vectors++;
        if (occupancy !== 4'd0 || out_valid !== 8'h00) begin
            miscompares++;
            $display("FAIL drain_all: got occ %0d valid %h want 0 00", occupancy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] sels [3] = '{3'd1, 3'd4, 3'd6};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sel   = sels[i];
            in_data  = 32'hB000_0000 | 32'(i);
            step();
        end
        vectors++;
        if (out_valid !== 8'h52 || occupancy !== 4'd3) begin
            miscompares++;
            $display("FAIL mid_fill: got valid %h occ %0d want 52 3", out_valid, occupancy);
        end
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 32'h0BAD_F00D;
        step();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid %h occ %0d want 00 0", out_valid, occupancy);
        end
        vectors++;
        if (slot(0) !== '0 || slot(1) !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: got ch0 %h ch1 %h want 0 0", slot(0), slot(1));
        end
    endtask

    task automatic test_random();
        logic [7:0]   mv;
        logic [W-1:0] md [8];
        logic         exp_ready;
        logic [W-1:0] seq;
        int           pc;
        mv  = 8'h00;
        seq = 32'h1000_0000;
        for (int j = 0; j < 8; j++) md[j] = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = seq;
            out_ready = 8'($urandom) & 8'($urandom);
            #1;
            exp_ready = ~mv[in_sel] | out_ready[in_sel];
            vectors++;
            if (in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            for (int j = 0; j < 8; j++) begin
                if (mv[j] && out_ready[j]) begin
                    vectors++;
                    if (slot(j) !== md[j]) begin
                        miscompares++;
                        $display("FAIL rnd_order cyc=%0d ch=%0d: got %h want %h",
                                 cyc, j, slot(j), md[j]);
                    end
                end
            end
            for (int j = 0; j < 8; j++) begin
                if (in_valid && exp_ready && in_sel == 3'(j)) begin
                    mv[j] = 1'b1;
                    md[j] = seq;
                end else if (mv[j] && out_ready[j]) begin
                    mv[j] = 1'b0;
                end
            end
            if (in_valid && exp_ready) seq = seq + 32'd1;
            step();
            pc = $countones(mv);
            vectors++;
            if (out_valid !== mv || occupancy !== 4'(pc)) begin
                miscompares++;
                $display("FAIL rnd_state cyc=%0d: got valid %h occ %0d want %h %0d",
                         cyc, out_valid, occupancy, mv, pc);
            end
        end
        in_valid  = 1'b0;
        out_ready = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_backpressure();
        test_drain_refill();
        test_fill_all();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
